// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants and state encoding for the load-multiple / store-multiple sequencer.
package lmsm_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int NREGS  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lmsm_sequencer_prio_enc.sv
// Lowest-set-bit priority encoder: 8-bit request vector to 3-bit index plus valid.
module prio_enc_8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the last hit, i.e. the lowest set bit, wins.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks a register list in ascending order, one memory transfer per set bit.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rf_write_n,
  output logic [REG_AW-1:0] rf_write_select,
  output logic [REG_AW-1:0] rf_read_add,
  output logic [DATA_W-1:0] rf_wdata
);

  state_t             state;
  logic               load_q;
  logic [NREGS-1:0]   mask_q;
  logic [NREGS-1:0]   mask_next;
  logic [REG_AW-1:0]  cur_reg;
  logic [REG_AW-1:0]  low_idx;
  logic               low_valid;

  prio_enc_8 u_prio_enc (
    .req   (mask_q),
    .idx   (low_idx),
    .valid (low_valid)
  );

  assign mask_next = mask_q & ~(NREGS'(1) << cur_reg);

  // mem_addr doubles as the running address counter; it wraps silently at 2^DATA_W.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: only control/datapath flops live here, so every one of them gets a reset value.
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      cur_reg  <= '0;
      mask_q   <= '0;
      load_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask_q   <= reg_mask;
            mem_addr <= base_addr;
            load_q   <= is_load;
            busy     <= 1'b1;
            if (reg_mask == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          cur_reg <= low_idx;
          if (low_valid) begin
            state  <= S_XFER;
            mem_rd <= load_q;
            mem_wr <= ~load_q;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            mask_q   <= mask_next;
            mem_addr <= mem_addr + 1'b1;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            if (mask_next == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe derives from the async-reset state, so reset releases it without waiting for a clock.
  assign rf_write_n      = ~((state == S_XFER) & load_q & mem_ready);
  assign rf_write_select = cur_reg;
  assign rf_read_add     = cur_reg;
  assign rf_wdata        = mem_rdata;
  assign mem_wdata       = rf_rdata;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer with a behavioural 8x16 register file and address-derived memory.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  reg_mask = '0;
  logic [15:0] base_addr = '0;
  logic [15:0] mem_rdata;
  logic [15:0] rf_rdata;
  logic        busy, done, mem_rd, mem_wr, rf_write_n;
  logic [15:0] mem_addr, mem_wdata, rf_wdata;
  logic [2:0]  rf_write_select, rf_read_add;

  lmsm_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .is_load         (is_load),
    .reg_mask        (reg_mask),
    .base_addr       (base_addr),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .rf_rdata        (rf_rdata),
    .busy            (busy),
    .done            (done),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_wdata       (mem_wdata),
    .rf_write_n      (rf_write_n),
    .rf_write_select (rf_write_select),
    .rf_read_add     (rf_read_add),
    .rf_wdata        (rf_wdata)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                          16'h1004, 16'h1005, 16'h1006, 16'h1007};

  always @(posedge clk) if (!rf_write_n) rf[rf_write_select] <= rf_wdata;

  assign mem_rdata = mem_addr ^ 16'hA5A5;
  assign rf_rdata  = rf[rf_read_add];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          cyc_done, n_rd, n_wr, n_wn, n_wn_bad, n_unstable, n_x;
  logic        busy1;
  logic [15:0] xa [8];
  logic [15:0] xd [8];
  logic [2:0]  xs [8];

  // Runs one sequence, stalling each transfer `stall` cycles, optionally re-pulsing start mid-run.
  task automatic run_seq(input logic ld, input logic [7:0] mask, input logic [15:0] base,
                         input int stall, input bit repulse);
    int          wait_cnt = 0;
    logic [15:0] held = '0;
    logic        active;
    cyc_done = 0; n_rd = 0; n_wr = 0; n_wn = 0; n_wn_bad = 0; n_unstable = 0; n_x = 0;
    busy1 = 1'b0;
    @(negedge clk);
    is_load = ld; reg_mask = mask; base_addr = base; start = 1'b1; mem_ready = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      start     = repulse && (c == 2 || c == 3);
      is_load   = ~ld;
      reg_mask  = 8'hFF;
      base_addr = 16'h1234;
      active    = mem_rd | mem_wr;
      mem_ready = active && (wait_cnt >= stall);
      #1;
      if (c == 1) busy1 = busy;
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
      if (!rf_write_n) begin
        n_wn++;
        if (!mem_ready) n_wn_bad++;
      end
      if (active) begin
        if (wait_cnt == 0) held = mem_addr;
        else if (mem_addr !== held) n_unstable++;
        if (mem_ready) begin
          if (n_x < 8) begin
            xa[n_x] = mem_addr;
            xd[n_x] = mem_rd ? rf_wdata : mem_wdata;
            xs[n_x] = mem_rd ? rf_write_select : rf_read_add;
          end
          n_x++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (done) begin
        cyc_done = c;
        break;
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_rf_write_n", 32'(rf_write_n), 32'd1);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cur_reg", 32'(rf_read_add), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: LM mask 0x05 from 0x0010
    run_seq(1'b1, 8'h05, 16'h0010, 0, 1'b0);
    check("t1_done_cycle", cyc_done, 5);
    check("t1_busy", 32'(busy1), 32'd1);
    check("t1_wn_lows", n_wn, 2);
    check("t1_rd", n_rd, 2);
    check("t1_wr", n_wr, 0);
    check("t1_xfers", n_x, 2);
    check("t1_a0", 32'(xa[0]), 32'h0010);
    check("t1_d0", 32'(xd[0]), 32'hA5B5);
    check("t1_s0", 32'(xs[0]), 32'd0);
    check("t1_a1", 32'(xa[1]), 32'h0011);
    check("t1_d1", 32'(xd[1]), 32'hA5B4);
    check("t1_s1", 32'(xs[1]), 32'd2);
    check("t1_r0", 32'(rf[0]), 32'hA5B5);
    check("t1_r1", 32'(rf[1]), 32'h1001);
    check("t1_r2", 32'(rf[2]), 32'hA5B4);

    // 2: SM mask 0xC0 from 0xFFFF, address wraps
    run_seq(1'b0, 8'hC0, 16'hFFFF, 0, 1'b0);
    check("t2_done_cycle", cyc_done, 5);
    check("t2_wr", n_wr, 2);
    check("t2_rd", n_rd, 0);
    check("t2_wn_lows", n_wn, 0);
    check("t2_a0", 32'(xa[0]), 32'hFFFF);
    check("t2_d0", 32'(xd[0]), 32'h1006);
    check("t2_s0", 32'(xs[0]), 32'd6);
    check("t2_a1", 32'(xa[1]), 32'h0000);
    check("t2_d1", 32'(xd[1]), 32'h1007);
    check("t2_s1", 32'(xs[1]), 32'd7);

    // 3: empty mask
    run_seq(1'b1, 8'h00, 16'h0300, 0, 1'b0);
    check("t3_done_cycle", cyc_done, 1);
    check("t3_busy", 32'(busy1), 32'd1);
    check("t3_rd", n_rd, 0);
    check("t3_wr", n_wr, 0);
    check("t3_wn_lows", n_wn, 0);

    // 4: LM mask 0x01 with three wait cycles
    run_seq(1'b1, 8'h01, 16'h0040, 3, 1'b0);
    check("t4_done_cycle", cyc_done, 6);
    check("t4_rd_cycles", n_rd, 4);
    check("t4_addr_unstable", n_unstable, 0);
    check("t4_wn_lows", n_wn, 1);
    check("t4_wn_not_ready", n_wn_bad, 0);
    check("t4_a0", 32'(xa[0]), 32'h0040);
    check("t4_r0", 32'(rf[0]), 32'hA5E5);

    // 5: start re-pulsed while busy
    run_seq(1'b1, 8'h0A, 16'h0100, 0, 1'b1);
    check("t5_done_cycle", cyc_done, 5);
    check("t5_xfers", n_x, 2);
    check("t5_rd", n_rd, 2);
    check("t5_wr", n_wr, 0);
    check("t5_a0", 32'(xa[0]), 32'h0100);
    check("t5_s0", 32'(xs[0]), 32'd1);
    check("t5_d0", 32'(xd[0]), 32'hA4A5);
    check("t5_a1", 32'(xa[1]), 32'h0101);
    check("t5_s1", 32'(xs[1]), 32'd3);
    check("t5_d1", 32'(xd[1]), 32'hA4A4);

    // 6: reset while the second LM write of mask 0x0F is pending
    @(negedge clk);
    is_load = 1'b1; reg_mask = 8'h0F; base_addr = 16'h0200; start = 1'b1; mem_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("t6_pre_wn", 32'(rf_write_n), 32'd0);
    check("t6_pre_addr", 32'(mem_addr), 32'h0201);
    reset = 1'b0;
    #1;
    check("t6_rst_wn", 32'(rf_write_n), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rd", 32'(mem_rd), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("t6_busy_idle", 32'(busy), 32'd0);
    check("t6_r0", 32'(rf[0]), 32'hA7A5);
    check("t6_r1", 32'(rf[1]), 32'hA4A5);
    check("t6_r2", 32'(rf[2]), 32'hA5B4);
    check("t6_r3", 32'(rf[3]), 32'hA4A4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
